fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
- Instruction queue between the fetch stage (PC generation plus instruction memory read) and decode.
- Buffers PC/instruction pairs in a small first-word-fall-through FIFO so fetch keeps running while decode stalls.
- On a taken branch/jump redirect, a single-cycle flush discards all wrong-path entries.
- Output side presents a RISC-V NOP when empty so decode never sees stale data.

Parameters:
- ADDRESS_BITS, 16, width of PC fields (matches fetch).
- DATA_WIDTH, 32, instruction width.
- DEPTH, 4, number of entries; power of two, at least 2.

Ports:
- clock  input  1  single system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- flush  input  1  redirect; driven by the same signal as fetch next_PC_select.
- in_valid  input  1  fetch/imem presents a valid pair this cycle.
- in_ready  output  1  queue can accept a pair this cycle.
- in_PC  input  ADDRESS_BITS  PC of the incoming instruction.
- in_instruction  input  DATA_WIDTH  instruction word read at in_PC.
- out_valid  output  1  head entry valid for decode.
- out_ready  input  1  decode consumes the head this cycle.
- out_PC  output  ADDRESS_BITS  PC of the head entry.
- out_instruction  output  DATA_WIDTH  instruction of the head entry.
- count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.

Behaviour:
- Reset, applied synchronously on the rising edge with reset=1: rd_ptr=wr_ptr=0, count=0. Resulting outputs: out_valid=0, in_ready=1, out_PC=0, out_instruction=32'h00000013. Reset has priority over flush, push and pop.
- Push occurs when in_valid & in_ready: entry written at wr_ptr, wr_ptr increments modulo DEPTH.
- Pop occurs when out_valid & out_ready: rd_ptr increments modulo DEPTH.
- in_ready = (count != DEPTH). It is a registered-state function only, with no combinational path from out_ready.
- out_valid = (count != 0).
- out_PC/out_instruction show the entry at rd_ptr combinationally (first-word-fall-through). A pushed entry becomes visible on out_* the cycle after the push, so latency is 1 cycle.
- When empty: out_PC=0, out_instruction=32'h00000013 (addi x0,x0,0).
- Count updates:
  - push only: +1
  - pop only: -1
  - both push and pop: unchanged; valid when 0<count<DEPTH, and when empty nothing pops.
- Full: in_ready=0. A simultaneous pop does not admit a push in the same cycle.
- Empty: a pop is impossible (out_valid=0), and out_ready is ignored.
- Flush: next cycle rd_ptr=wr_ptr=0 and count=0. Any push or pop in the flush cycle is discarded. The fetch target-PC entry arrives on a later cycle.
- Pointers wrap from DEPTH-1 to 0. Storage contents are not cleared by reset or flush; they are never observable while empty.
- Flush and reset asserted mid-stall (count=DEPTH, out_ready=0) behave identically to the general case.

Decomposition:
- Shared package core_pkg holds:
  - ADDRESS_BITS/DATA_WIDTH defaults
  - NOP_INSTRUCTION = 32'h00000013
  - a packed typedef fetch_entry_t {PC, instruction}
- One natural sub-module: fetch_queue_storage, a DEPTH x entry register array with a single write port and a single asynchronous read port.
- Pointer/count control stays in fetch_queue.

Test Plan:
- Reset → after release: count=0, out_valid=0, in_ready=1, out_instruction=32'h00000013, out_PC=0.
- Push (PC=0x0000, 0x00500093) with out_ready=0 → next cycle: out_valid=1, out_PC=0x0000, out_instruction=0x00500093, count=1.
- Push PCs 0x0000/0x0004/0x0008/0x000C with out_ready=0 → count=4, in_ready=0. A fifth push of 0x0010 is refused and leaves contents unchanged. Draining then yields the four entries in order; the output reverts to NOP at count=0.
- Continuous push every cycle with out_ready=1 from an empty queue → count stays at 1; out_PC follows 0x0000, 0x0004, ... one cycle behind in_PC; no drops across 8+ pushes, exercising pointer wrap.
- Fill with 3 entries, assert flush together with in_valid (PC=0x0020) → next cycle: count=0, out_valid=0, and PC=0x0020 is absent. A push of target PC 0x0040 the following cycle appears at the head.
- Fill to 4, assert reset for 1 cycle while out_ready=1 and in_valid=1 → next cycle: all reset values hold; no entry was pushed or popped.

Source files
------------

// File: rtl/core_pkg.sv
// Shared fetch/decode types and constants.
package core_pkg;

  localparam int unsigned DEFAULT_ADDRESS_BITS = 16;
  localparam int unsigned DEFAULT_DATA_WIDTH   = 32;

  // addi x0,x0,0 -- presented to decode whenever the queue is empty
  localparam logic [31:0] NOP_INSTRUCTION = 32'h00000013;

  typedef struct packed {
    logic [DEFAULT_ADDRESS_BITS-1:0] pc;
    logic [DEFAULT_DATA_WIDTH-1:0]   instruction;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_storage.sv
// Entry array for the fetch queue: one write port, one asynchronous read port.
module fetch_queue_storage
  import core_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic               clock,
  input  logic               wr_en_i,
  input  logic [PTR_W-1:0]   wr_addr_i,
  input  fetch_entry_t       wr_data_i,
  input  logic [PTR_W-1:0]   rd_addr_i,
  output fetch_entry_t       rd_data_o
);

  fetch_entry_t mem_q [DEPTH];

  // Write port; contents are never cleared, only overwritten.
  always_ff @(posedge clock) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/fetch_queue.sv
// First-word-fall-through PC/instruction queue between fetch and decode,
// with single-cycle flush on redirect and NOP presented when empty.
module fetch_queue
  import core_pkg::*;
#(
  parameter  int unsigned ADDRESS_BITS = DEFAULT_ADDRESS_BITS,
  parameter  int unsigned DATA_WIDTH   = DEFAULT_DATA_WIDTH,
  parameter  int unsigned DEPTH        = 4,
  localparam int unsigned CNT_W        = $clog2(DEPTH) + 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [ADDRESS_BITS-1:0] in_PC,
  input  logic [DATA_WIDTH-1:0]   in_instruction,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ADDRESS_BITS-1:0] out_PC,
  output logic [DATA_WIDTH-1:0]   out_instruction,
  output logic [CNT_W-1:0]        count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  // Entry layout is shared with fetch through core_pkg, so widths must match it.
  if (ADDRESS_BITS != DEFAULT_ADDRESS_BITS || DATA_WIDTH != DEFAULT_DATA_WIDTH) begin : g_width_check
    $error("fetch_queue: ADDRESS_BITS/DATA_WIDTH must match core_pkg entry layout");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
    $error("fetch_queue: DEPTH must be a power of two and at least 2");
  end

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;

  logic         push;
  logic         pop;
  logic         wr_en;
  fetch_entry_t wr_entry;
  fetch_entry_t head_entry;

  // Handshakes depend only on registered occupancy.
  assign in_ready  = (count_q != CNT_W'(DEPTH));
  assign out_valid = (count_q != '0);
  assign count     = count_q;

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  // A push in a flush or reset cycle is discarded, so it never touches storage.
  assign wr_en    = push & ~flush & ~reset;
  assign wr_entry = '{pc: in_PC, instruction: in_instruction};

  fetch_queue_storage #(
    .DEPTH (DEPTH)
  ) u_storage (
    .clock     (clock),
    .wr_en_i   (wr_en),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (wr_entry),
    .rd_addr_i (rd_ptr_q),
    .rd_data_o (head_entry)
  );

  // Next pointer/occupancy; flush empties the queue and drops this cycle's traffic.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer/occupancy registers with synchronous reset taking priority.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Head fall-through, masked to a NOP at PC 0 when empty.
  always_comb begin
    out_PC          = '0;
    out_instruction = DATA_WIDTH'(NOP_INSTRUCTION);
    if (out_valid) begin
      out_PC          = head_entry.pc;
      out_instruction = head_entry.instruction;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with a queue-based reference model.
module tb_fetch_queue;
  import core_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic        clock;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_PC;
  logic [31:0] in_instruction;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_PC;
  logic [31:0] out_instruction;
  logic [CNT_W-1:0] count;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_queue #(
    .ADDRESS_BITS (16),
    .DATA_WIDTH   (32),
    .DEPTH        (DEPTH)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .flush           (flush),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_PC           (in_PC),
    .in_instruction  (in_instruction),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_PC          (out_PC),
    .out_instruction (out_instruction),
    .count           (count)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Distinct instruction per PC; PC 0 maps to addi x1,x0,5 (0x00500093).
  function automatic logic [31:0] instr_of(input logic [15:0] pc);
    return ((32'(pc) + 32'd5) << 20) | 32'h00000093;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an ordered list of pending entries.
  fetch_entry_t model_q[$];
  bit started = 1'b0;

  always @(posedge clock) begin
    bit m_push;
    bit m_pop;
    if (reset) begin
      model_q.delete();
      started = 1'b1;
    end else if (flush) begin
      model_q.delete();
    end else begin
      m_push = in_valid && (model_q.size() < DEPTH);
      m_pop  = out_ready && (model_q.size() > 0);
      if (m_pop) void'(model_q.pop_front());
      if (m_push) model_q.push_back('{pc: in_PC, instruction: in_instruction});
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clock) begin
    if (started) begin
      chk("m_count", 64'(count), 64'(model_q.size()));
      chk("m_out_valid", 64'(out_valid), 64'(model_q.size() != 0));
      chk("m_in_ready", 64'(in_ready), 64'(model_q.size() < DEPTH));
      if (model_q.size() != 0) begin
        chk("m_out_PC", 64'(out_PC), 64'(model_q[0].pc));
        chk("m_out_instr", 64'(out_instruction), 64'(model_q[0].instruction));
      end else begin
        chk("m_out_PC_empty", 64'(out_PC), 64'h0);
        chk("m_out_instr_empty", 64'(out_instruction), 64'h13);
      end
    end
  end

  // Apply one cycle of inputs (set at the falling edge, held across the rising edge).
  task automatic drive(input logic rst, input logic fl, input logic iv,
                       input logic [15:0] pc, input logic ordy);
    reset          = rst;
    flush          = fl;
    in_valid       = iv;
    in_PC          = pc;
    in_instruction = instr_of(pc);
    out_ready      = ordy;
    @(negedge clock);
  endtask

  task automatic chk_empty(input string tag);
    chk({tag, "_count"}, 64'(count), 64'd0);
    chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    chk({tag, "_out_PC"}, 64'(out_PC), 64'h0);
    chk({tag, "_out_instr"}, 64'(out_instruction), 64'h00000013);
  endtask

  initial begin
    // Reset
    drive(1, 0, 0, 16'h0, 0);
    drive(1, 0, 0, 16'h0, 0);
    drive(0, 0, 0, 16'h0, 0);
    chk_empty("reset");

    // Single push, visible next cycle
    drive(0, 0, 1, 16'h0000, 0);
    chk("push1_valid", 64'(out_valid), 64'd1);
    chk("push1_PC", 64'(out_PC), 64'h0000);
    chk("push1_instr", 64'(out_instruction), 64'h00500093);
    chk("push1_count", 64'(count), 64'd1);

    // Fill to full, refused fifth push
    drive(0, 0, 1, 16'h0004, 0);
    drive(0, 0, 1, 16'h0008, 0);
    drive(0, 0, 1, 16'h000C, 0);
    chk("full_count", 64'(count), 64'd4);
    chk("full_in_ready", 64'(in_ready), 64'd0);
    drive(0, 0, 1, 16'h0010, 0);
    chk("refused_count", 64'(count), 64'd4);
    chk("refused_head", 64'(out_PC), 64'h0000);

    // Drain in order
    for (int i = 0; i < 4; i++) begin
      chk("drain_PC", 64'(out_PC), 64'(i * 4));
      chk("drain_instr", 64'(out_instruction), 64'(instr_of(16'(i * 4))));
      drive(0, 0, 0, 16'h0, 1);
    end
    chk_empty("drained");
    drive(0, 0, 0, 16'h0, 1);
    chk("empty_ready_ignored", 64'(count), 64'd0);

    // Streaming push+pop, wrapping pointers
    for (int k = 0; k < 10; k++) begin
      drive(0, 0, 1, 16'(k * 4), 1);
      chk("stream_count", 64'(count), 64'd1);
      chk("stream_PC", 64'(out_PC), 64'(k * 4));
    end
    drive(0, 0, 0, 16'h0, 1);
    chk("stream_drained", 64'(count), 64'd0);

    // Flush with a concurrent push
    drive(0, 0, 1, 16'h0010, 0);
    drive(0, 0, 1, 16'h0014, 0);
    drive(0, 0, 1, 16'h0018, 0);
    chk("preflush_count", 64'(count), 64'd3);
    drive(0, 1, 1, 16'h0020, 0);
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    drive(0, 0, 1, 16'h0040, 0);
    chk("target_PC", 64'(out_PC), 64'h0040);
    chk("target_instr", 64'(out_instruction), 64'(instr_of(16'h0040)));
    chk("target_count", 64'(count), 64'd1);

    // Flush during a full stall
    drive(0, 0, 1, 16'h0044, 0);
    drive(0, 0, 1, 16'h0048, 0);
    drive(0, 0, 1, 16'h004C, 0);
    chk("stall_count", 64'(count), 64'd4);
    drive(0, 1, 1, 16'h0050, 0);
    chk_empty("stall_flush");

    // Reset while full with push and pop requested
    drive(0, 0, 1, 16'h0060, 0);
    drive(0, 0, 1, 16'h0064, 0);
    drive(0, 0, 1, 16'h0068, 0);
    drive(0, 0, 1, 16'h006C, 0);
    chk("prereset_count", 64'(count), 64'd4);
    drive(1, 0, 1, 16'h0070, 1);
    chk_empty("full_reset");
    drive(0, 0, 0, 16'h0, 0);
    chk_empty("post_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
